// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the ALU arbiter: instruction fields that
// drive ALU-control decode, the ALU-control encoding and the result-slot states.
package alu_arbiter_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_SUB   = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3
  } alu_ctrl_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Execute-stage ALU: 32-bit wrap-around arithmetic/logic selected by a
// 4-bit control code, purely combinational, no flags.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  alu_ctrl_t   ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = a + b;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with a single
// registered, tagged response slot and a saturating backpressure counter.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*7-1:0]    req_opcode,
  input  logic [NUM_REQ*3-1:0]    req_funct3,
  input  logic [NUM_REQ*7-1:0]    req_funct7,
  input  logic [NUM_REQ*32-1:0]   req_op1,
  input  logic [NUM_REQ*32-1:0]   req_op2,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic [CNT_W-1:0]        stall_cnt
);

  // Handshake: a request transfers on the edge where req_valid[i] & req_ready[i];
  // the result transfers on the edge where rsp_valid & rsp_ready. req_ready never
  // looks at the op fields, and once rsp_valid rises the slot holds until accepted.

  function automatic alu_ctrl_t decode_ctrl(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
    decode_ctrl = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct3)
        3'b000:  decode_ctrl = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        3'b111:  decode_ctrl = ALU_AND;
        3'b110:  decode_ctrl = ALU_OR;
        default: decode_ctrl = ALU_ADD;
      endcase
    end
  endfunction

  slot_state_t          state_q;
  slot_state_t          state_d;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_found;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic                 slot_free;
  logic                 transfer;
  alu_ctrl_t            sel_ctrl;
  logic [31:0]          sel_op1;
  logic [31:0]          sel_op2;
  logic [31:0]          alu_result;

  // Rotating priority search: the first valid requester at or after ptr_q wins.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (grant_found) grant_onehot[grant_idx] = 1'b1;
  end

  assign slot_free = (state_q == ST_EMPTY) || rsp_ready;
  assign transfer  = grant_found && slot_free && !rst;
  assign req_ready = grant_onehot & {NUM_REQ{slot_free && !rst}};

  always_comb begin
    sel_op1  = req_op1[32*grant_idx +: 32];
    sel_op2  = req_op2[32*grant_idx +: 32];
    sel_ctrl = decode_ctrl(req_opcode[7*grant_idx +: 7],
                           req_funct3[3*grant_idx +: 3],
                           req_funct7[7*grant_idx +: 7]);
  end

  alu_arbiter_alu u_alu (
    .ctrl   (sel_ctrl),
    .a      (sel_op1),
    .b      (sel_op2),
    .result (alu_result)
  );

  // A transfer always (re)fills the slot, including the same edge the old result leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (transfer) state_d = ST_FULL;
      ST_FULL: begin
        if (transfer)       state_d = ST_FULL;
        else if (rsp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      stall_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        rsp_result <= alu_result;
        rsp_id     <= grant_idx;
        ptr_q      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if ((state_q == ST_FULL) && !rsp_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed reset/fairness/backpressure
// sequences, a decode vector table, and randomized traffic against a reference model.
module tb_alu_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int EW      = ID_W + 32;
  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;
  localparam logic [6:0] SUBF = 7'b0100000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic [NUM_REQ*7-1:0]  req_opcode;
  logic [NUM_REQ*3-1:0]  req_funct3;
  logic [NUM_REQ*7-1:0]  req_funct7;
  logic [NUM_REQ*32-1:0] req_op1;
  logic [NUM_REQ*32-1:0] req_op2;
  logic                  rsp_valid, rsp_valid_s;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id, rsp_id_s;
  logic [31:0]           rsp_result, rsp_result_s;
  logic [15:0]           stall_cnt;
  logic [3:0]            stall_cnt_s;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_op1(req_op1), .req_op2(req_op2), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .stall_cnt(stall_cnt)
  );

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_op1(req_op1), .req_op2(req_op2), .rsp_valid(rsp_valid_s),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id_s), .rsp_result(rsp_result_s),
    .stall_cnt(stall_cnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [6:0] opc,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]          = v;
    req_opcode[7*i +: 7]  = opc;
    req_funct3[3*i +: 3]  = f3;
    req_funct7[7*i +: 7]  = f7;
    req_op1[32*i +: 32]   = a;
    req_op2[32*i +: 32]   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b);
    if (opc == R_OP) begin
      if (f3 == 3'b000 && f7 == SUBF) return a - b;
      if (f3 == 3'b111) return a & b;
      if (f3 == 3'b110) return a | b;
    end
    return a + b;
  endfunction

  typedef struct {
    int          id;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, R_OP, 3'b000, SUBF,     32'd5,          32'd7,          32'hFFFF_FFFE};
    vecs[1] = '{0, R_OP, 3'b111, 7'd0,     32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0};
    vecs[2] = '{1, I_OP, 3'b000, 7'd0,     32'd3,          32'd4,          32'd7};
    vecs[3] = '{1, R_OP, 3'b110, 7'd0,     32'h0000_F000,  32'h0000_000F,  32'h0000_F00F};
    vecs[4] = '{0, R_OP, 3'b000, 7'd0,     32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
    vecs[5] = '{1, R_OP, 3'b001, 7'd0,     32'd10,         32'd20,         32'h0000_001E};
    vecs[6] = '{0, I_OP, 3'b000, SUBF,     32'd9,          32'd1,          32'd10};
    vecs[7] = '{1, R_OP, 3'b111, SUBF,     32'h0000_FF00,  32'h0000_0FF0,  32'h0000_0F00};
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
    req_op1 = '0; req_op2 = '0;

    // Reset with both requesters asserting; req0 computes 1+2, req1 computes 0x100|0x001.
    set_req(0, 1'b1, R_OP, 3'b000, 7'd0, 32'd1, 32'd2);
    set_req(1, 1'b1, R_OP, 3'b110, 7'd0, 32'h100, 32'h001);
    tick(); tick();
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);

    // Fairness: continuous requests alternate with no bubbles.
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("fair_req_ready", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check("fair_rsp_valid", 32'(rsp_valid), 32'd1);
      check("fair_rsp_id", 32'(rsp_id), 32'(c % 2));
      check("fair_rsp_result", rsp_result, (c % 2 == 0) ? 32'd3 : 32'h101);
    end

    // Backpressure: slot holds the id1 result for three cycles.
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(rsp_id), 32'd1);
      check("bp_rsp_result", rsp_result, 32'h101);
      check("bp_stall_cnt", 32'(stall_cnt), 32'(c + 1));
      check("bp_stall_cnt_sat", 32'(stall_cnt_s), 32'(c + 1));
    end
    rsp_ready = 1'b1;
    #1;
    check("resume_req_ready", 32'(req_ready), 32'd1);
    tick();
    check("resume_rsp_id", 32'(rsp_id), 32'd0);
    check("resume_rsp_result", rsp_result, 32'd3);
    check("resume_stall_cnt", 32'(stall_cnt), 32'd3);

    // Saturation: 20 more stalled cycles; 4-bit counter stops at 15.
    rsp_ready = 1'b0;
    repeat (20) tick();
    check("sat_stall_cnt16", 32'(stall_cnt), 32'd23);
    check("sat_stall_cnt4", 32'(stall_cnt_s), 32'd15);
    check("sat_rsp_id_held", 32'(rsp_id), 32'd0);

    // Reset mid-operation: slot dropped, pointer (currently 1) returns to 0.
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    tick();
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_result", rsp_result, 32'd0);
    check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("midrst_stall_cnt4", 32'(stall_cnt_s), 32'd0);
    rst = 1'b0; rsp_ready = 1'b1;
    #1;
    check("midrst_ptr_zero", 32'(req_ready), 32'd1);
    tick();
    check("midrst_first_id", 32'(rsp_id), 32'd0);

    // Decode vectors: one requester at a time, result the next cycle.
    req_valid = '0;
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].id, 1'b1, vecs[v].opc, vecs[v].f3, vecs[v].f7, vecs[v].a, vecs[v].b);
      #1;
      check("vec_req_ready", 32'(req_ready), 32'(1 << vecs[v].id));
      tick();
      req_valid = '0;
      check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      check("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      check("vec_rsp_result", rsp_result, vecs[v].exp);
    end

    // Randomized traffic against the reference model, starting from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    begin
      int m_ptr, m_stall, m_stall4, win;
      logic [NUM_REQ-1:0] exp_rdy;
      logic busy;
      m_ptr = 0; m_stall = 0; m_stall4 = 0;
      for (int n = 0; n < 400; n++) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NUM_REQ; i++) begin
          logic [6:0] opc;
          int sel;
          sel = $urandom_range(0, 2);
          opc = (sel == 0) ? R_OP : (sel == 1) ? I_OP : 7'($urandom);
          set_req(i, 1'($urandom_range(0, 1)), opc, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) != 0) ? SUBF : 7'($urandom), $urandom, $urandom);
        end
        #1;
        busy = (exp_q.size() != 0);
        win = -1;
        for (int k = 0; k < NUM_REQ; k++)
          if (win < 0 && req_valid[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
        exp_rdy = '0;
        if (win >= 0 && (!busy || rsp_ready)) exp_rdy[win] = 1'b1;
        check("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rnd_req_ready4", 32'(req_ready_s), 32'(exp_rdy));
        if (busy && !rsp_ready) begin
          if (m_stall < 65535) m_stall++;
          if (m_stall4 < 15) m_stall4++;
        end
        if (busy && rsp_ready) void'(exp_q.pop_front());
        if (exp_rdy != '0) begin
          exp_q.push_back({ID_W'(win), ref_alu(req_opcode[7*win +: 7], req_funct3[3*win +: 3],
                           req_funct7[7*win +: 7], req_op1[32*win +: 32], req_op2[32*win +: 32])});
          m_ptr = (win + 1) % NUM_REQ;
        end
        tick();
        check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("rnd_rsp_id", 32'(rsp_id), 32'(exp_q[0][EW-1:32]));
          check("rnd_rsp_result", rsp_result, exp_q[0][31:0]);
        end
        check("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("rnd_stall_cnt4", 32'(stall_cnt_s), 32'(m_stall4));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
